// File: rtl/convpress_node_ctrl.sv
// Sequencer for one convpress node: walks NBin/NBout tiles and drives datapath controls.
// Latency: per output tile 1 LOAD + Ni STREAM beats + PIPE_LAT drain + 1 WRITE cycle.
// Backpressure: i_sb_ready low inserts a STREAM bubble; the same beat is offered next cycle.
module convpress_node_ctrl #(
  parameter int ADDR_SZ  = 6,
  parameter int CNT_SZ   = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [CNT_SZ-1:0]  i_cfg_num_in,
  input  logic [CNT_SZ-1:0]  i_cfg_num_out,
  input  logic [ADDR_SZ-1:0] i_cfg_nbin_base,
  input  logic [ADDR_SZ-1:0] i_cfg_nbout_base,
  input  logic               i_cfg_final,
  input  logic               i_sb_ready,
  output logic [ADDR_SZ-1:0] o_nbin_addr,
  output logic               o_sb_req,
  output logic [ADDR_SZ-1:0] o_nbout_addr,
  output logic               o_nbout_wen,
  output logic               o_load_nbout,
  output logic               o_n1_n2_to_nbout,
  output logic               o_acc_en,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]          state;
  logic [CNT_SZ-1:0]   cfg_num_in;
  logic [CNT_SZ-1:0]   cfg_num_out;
  logic [ADDR_SZ-1:0]  cfg_nbin_base;
  logic                cfg_final;
  logic [CNT_SZ-1:0]   in_cnt;
  logic [CNT_SZ-1:0]   out_cnt;
  logic [ADDR_SZ-1:0]  in_ptr;
  logic [ADDR_SZ-1:0]  out_ptr;
  logic [ADDR_SZ-1:0]  nbin_addr_q;
  logic [ADDR_SZ-1:0]  nbout_addr_q;
  logic [PIPE_LAT-1:0] vld_sr;
  logic [PIPE_LAT-1:0] vld_sr_shift;
  logic                sb_req;
  logic                nbout_sel;
  logic                last_in;
  logic                last_out;

  assign sb_req       = (state == S_STREAM) && i_sb_ready;
  assign nbout_sel    = (state == S_LOAD) || (state == S_WRITE);
  assign last_in      = (in_cnt == cfg_num_in - CNT_SZ'(1));
  assign last_out     = (out_cnt == cfg_num_out - CNT_SZ'(1));
  // Contents of the valid pipe after this edge when no new beat enters (DRAIN never issues).
  assign vld_sr_shift = vld_sr << 1;

  // Main sequencer: config latch, tile pointers/counters and state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cfg_num_in    <= '0;
      cfg_num_out   <= '0;
      cfg_nbin_base <= '0;
      cfg_final     <= 1'b0;
      in_cnt        <= '0;
      out_cnt       <= '0;
      in_ptr        <= '0;
      out_ptr       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            cfg_num_in    <= i_cfg_num_in;
            cfg_num_out   <= i_cfg_num_out;
            cfg_nbin_base <= i_cfg_nbin_base;
            cfg_final     <= i_cfg_final;
            in_ptr        <= i_cfg_nbin_base;
            out_ptr       <= i_cfg_nbout_base;
            in_cnt        <= '0;
            out_cnt       <= '0;
            // An empty job skips the datapath entirely.
            if (i_cfg_num_in == '0 || i_cfg_num_out == '0) state <= S_DONE;
            else                                           state <= S_LOAD;
          end
        end
        S_LOAD: state <= S_STREAM;
        S_STREAM: begin
          if (i_sb_ready) begin
            in_ptr <= in_ptr + ADDR_SZ'(1);
            if (last_in) begin
              in_cnt <= '0;
              state  <= S_DRAIN;
            end else begin
              in_cnt <= in_cnt + CNT_SZ'(1);
            end
          end
        end
        S_DRAIN: begin
          // Leave as the last beat reaches N1, so WRITE follows the final acc_en directly.
          if (vld_sr_shift == '0) state <= S_WRITE;
        end
        S_WRITE: begin
          out_cnt <= out_cnt + CNT_SZ'(1);
          out_ptr <= out_ptr + ADDR_SZ'(1);
          in_ptr  <= cfg_nbin_base;
          state   <= last_out ? S_DONE : S_LOAD;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Valid pipe tracking issued beats down to the N1 accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= vld_sr_shift | PIPE_LAT'(sb_req);
  end

  // Address hold registers so addresses keep their last driven value between uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nbin_addr_q  <= '0;
      nbout_addr_q <= '0;
    end else begin
      if (sb_req)    nbin_addr_q  <= in_ptr;
      if (nbout_sel) nbout_addr_q <= out_ptr;
    end
  end

  assign o_sb_req         = sb_req;
  assign o_nbin_addr      = sb_req ? in_ptr : nbin_addr_q;
  assign o_nbout_addr     = nbout_sel ? out_ptr : nbout_addr_q;
  assign o_nbout_wen      = (state == S_WRITE);
  assign o_load_nbout     = (state == S_LOAD);
  assign o_n1_n2_to_nbout = (state == S_WRITE) && cfg_final;
  assign o_acc_en         = vld_sr[PIPE_LAT-1];
  assign o_busy           = (state != S_IDLE);
  assign o_done           = (state == S_DONE);

endmodule

// File: doc/convpress_node_ctrl.md
Name: convpress_node_ctrl

Overview:
Sequencer for one convpress compute node. It walks NBin input-tile addresses and NBout output-tile addresses. For each output tile it loads the stored partial sum from NBout, streams Ni input tiles through the multiplier/adder pipeline, then writes back either the partial sum or the sigmoid result. It sits between the layer-level host FSM and the node datapath, and drives the node's NBin/NBout addresses and its write, load, select and accumulate controls.

Parameters:
ADDR_SZ, 6, NBin/NBout address width
CNT_SZ, 8, width of tile counters
PIPE_LAT, 3, cycles from NBin address issue until the beat is summed into the N1/N2 register

Ports:
clk  in  1  node clock
rst  in  1  asynchronous active-high reset
i_start  in  1  one-cycle pulse; latches cfg_* when idle
i_cfg_num_in  in  CNT_SZ  input tiles per output tile (Ni)
i_cfg_num_out  in  CNT_SZ  output tiles per job (No)
i_cfg_nbin_base  in  ADDR_SZ  first NBin address
i_cfg_nbout_base  in  ADDR_SZ  first NBout address
i_cfg_final  in  1  1 = job completes the sum; write sigmoid output
i_sb_ready  in  1  SB/eDRAM beat available this cycle
o_nbin_addr  out  ADDR_SZ  NBin read address
o_sb_req  out  1  beat issued (NBin read + SB fetch) this cycle
o_nbout_addr  out  ADDR_SZ  NBout address (read or write)
o_nbout_wen  out  1  NBout write enable
o_load_nbout  out  1  select NBout into the N1/N2 register
o_n1_n2_to_nbout  out  1  1 = N2 (sigmoid) result to NBout, 0 = N1 partial sum
o_acc_en  out  1  N1 accumulates this cycle (valid beat at N1)
o_busy  out  1  job in progress
o_done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (async, rst=1): state IDLE; all counters, pointers and outputs 0.
- States: IDLE, LOAD, STREAM, DRAIN, WRITE, DONE. o_busy=1 in every state except IDLE.
- IDLE:
  - i_start latches all cfg_* inputs. in_ptr=nbin_base, out_ptr=nbout_base, both counters 0.
  - If num_in==0 or num_out==0: go to DONE (no datapath activity). Otherwise go to LOAD.
- LOAD (1 cycle): o_nbout_addr=out_ptr, o_load_nbout=1. Next state STREAM.
- STREAM:
  - i_sb_ready=1: o_sb_req=1, o_nbin_addr=in_ptr. Then in_ptr+1 (wraps mod 2^ADDR_SZ) and in_cnt+1.
  - On the beat where in_cnt==num_in-1: go to DRAIN and reset in_cnt.
  - i_sb_ready=0: o_sb_req=0, o_nbin_addr holds its value, no state change (bubble).
- Valid tracking: a PIPE_LAT-deep shift register carries o_sb_req. o_acc_en equals its output, so it asserts exactly PIPE_LAT cycles after each issued beat; bubbles never accumulate.
- DRAIN: stay until the shift register is empty, then go to WRITE.
- WRITE (1 cycle): o_nbout_wen=1, o_nbout_addr=out_ptr, o_n1_n2_to_nbout=cfg_final. Then:
  - out_cnt+1 and out_ptr+1 (wrapping).
  - in_ptr reloads nbin_base.
  - If out_cnt was num_out-1, go to DONE; otherwise go to LOAD.
- DONE (1 cycle): o_done=1. Next state IDLE.
- i_start is ignored while o_busy=1.
- Outside the states and conditions listed above, every control output is 0 and every address output holds its last value.
- Cycle count with no stalls = 1 + No*(Ni + PIPE_LAT + 2) + 1, counted from the i_start cycle through the o_done cycle.
- Simultaneous i_start and rst: rst wins.
- rst mid-job: state returns immediately to IDLE, the job is abandoned with no write, and the shift register clears.

Test Plan:
- Basic job: Ni=4, No=2, bases 0/10, final=0, sb_ready=1.
  - o_nbin_addr 0,1,2,3 then 0,1,2,3.
  - Two WRITE pulses at nbout_addr 10 and 11, with o_n1_n2_to_nbout=0.
  - o_done 1+2*9+1=20 cycles after start; o_acc_en 4 cycles per tile.
- Stalls: Ni=3, No=1, sb_ready pattern 1,0,0,1,1.
  - o_sb_req on exactly 3 cycles, addresses 0,1,2.
  - o_acc_en pulses at those cycles+3.
  - WRITE occurs only after the last acc_en.
- Final flag and wrap: final=1, nbin_base=62, Ni=3, nbout_base=63, No=2.
  - NBin addresses 62,63,0.
  - Writes at 63 then 0, both with o_n1_n2_to_nbout=1.
- Zero count: start with Ni=0. Response: o_done pulses 2 cycles later, with no sb_req, wen or load_nbout.
- Start while busy: a second i_start mid-STREAM with different cfg has no effect; the addresses follow the first cfg.
- Reset mid-DRAIN: rst asserts. All outputs go to 0 at once, no o_nbout_wen ever issues, and a new start after release runs normally.
